// File: rtl/bsg_mul_array_pkg.sv
// Shared definitions for the pipelined array multiplier.
// Holds default width, product width helper and product assembly.
package bsg_mul_array_pkg;

  localparam int width_default_lp = 16;
  localparam int max_width_lp = 64;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  // s[0] duplicates pa[w-1] and is dropped; c lands in the top bit.
  function automatic logic [2*max_width_lp-1:0] assemble_product(
    input int w,
    input logic [max_width_lp-1:0] s,
    input logic c,
    input logic [max_width_lp-1:0] pa
  );
    logic [2*max_width_lp-1:0] mask;
    logic [2*max_width_lp-1:0] s_x;
    logic [2*max_width_lp-1:0] pa_x;
    logic [2*max_width_lp-1:0] c_x;
    mask = ((2*max_width_lp)'(1) << w) - (2*max_width_lp)'(1);
    s_x = {{max_width_lp{1'b0}}, s} & mask;
    pa_x = {{max_width_lp{1'b0}}, pa} & mask;
    c_x = (2*max_width_lp)'(c) << (2 * w - 1);
    return pa_x | ((s_x >> 1) << w) | c_x;
  endfunction

endpackage

// File: rtl/bsg_mul_array_tail_fifo.sv
// 1r1w circular result buffer of els_p entries.
// Ports: w_v_i/w_data_i write, r_yumi_i pop, v_o/data_o head, count_o.
module bsg_mul_array_tail_fifo #(
  parameter int width_p = 32,
  parameter int els_p = 4,
  localparam int cnt_w_lp = $clog2(els_p + 1),
  localparam int ptr_w_lp = $clog2(els_p)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                w_v_i,
  input  logic [width_p-1:0]  w_data_i,
  input  logic                r_yumi_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic full, pop, push;

  assign v_o = (count_r != '0);
  assign full = (count_r == cnt_w_lp'(els_p));
  assign pop = r_yumi_i & v_o;
  // A pop in the same cycle frees the slot being written.
  assign push = w_v_i & (~full | pop);
  assign data_o = mem_r[rptr_r];
  assign count_o = count_r;

  function automatic logic [ptr_w_lp-1:0] inc(
    input logic [ptr_w_lp-1:0] p
  );
    if (p == ptr_w_lp'(els_p - 1)) return '0;
    return p + ptr_w_lp'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (push) mem_r[wptr_r] <= w_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      count_r <= '0;
    end else begin
      if (push) wptr_r <= inc(wptr_r);
      if (pop) rptr_r <= inc(rptr_r);
      if (push && !pop) count_r <= count_r + cnt_w_lp'(1);
      else if (pop && !push) count_r <= count_r - cnt_w_lp'(1);
    end
  end

endmodule

// File: rtl/bsg_mul_array_tail.sv
// Tail of the array multiplier: assembles products, buffers them,
// and grants issue credit. Ports: issue_v_i/issue_ready_o, v_i/s_i/
// c_i/prod_accum_i from last row, v_o/product_o/yumi_i to consumer.
module bsg_mul_array_tail
  import bsg_mul_array_pkg::*;
#(
  parameter int width_p = width_default_lp,
  parameter int els_p = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_v_i,
  output logic                 issue_ready_o,
  input  logic                 v_i,
  input  logic [width_p-1:0]   s_i,
  input  logic                 c_i,
  input  logic [width_p-1:0]   prod_accum_i,
  output logic                 v_o,
  output logic [2*width_p-1:0] product_o,
  input  logic                 yumi_i
);

  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam int pw_lp = 2 * width_p;

  logic [cnt_w_lp-1:0] inflight_r, fifo_count;
  logic [cnt_w_lp:0] used;
  logic issue_ok, wr;
  logic [max_width_lp-1:0] s_ext, pa_ext;
  logic [2*max_width_lp-1:0] product_full;
  logic [pw_lp-1:0] product;

  always_comb begin
    s_ext = '0;
    pa_ext = '0;
    s_ext[width_p-1:0] = s_i;
    pa_ext[width_p-1:0] = prod_accum_i;
    product_full = assemble_product(width_p, s_ext, c_i, pa_ext);
  end

  assign product = product_full[pw_lp-1:0];

  if (width_p < max_width_lp) begin : g_hi
    logic unused_prod_hi;
    assign unused_prod_hi = ^product_full[2*max_width_lp-1:pw_lp];
  end

  // Credit from registered state only; a pop frees credit next cycle.
  assign used = (cnt_w_lp+1)'(fifo_count) + (cnt_w_lp+1)'(inflight_r);
  assign issue_ready_o = used < (cnt_w_lp+1)'(els_p);
  assign issue_ok = issue_v_i & issue_ready_o;
  // A result with nothing in flight is spurious and dropped.
  assign wr = v_i & (inflight_r != '0);

  bsg_mul_array_tail_fifo #(
    .width_p (pw_lp),
    .els_p   (els_p)
  ) fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .w_v_i    (wr),
    .w_data_i (product),
    .r_yumi_i (yumi_i),
    .v_o      (v_o),
    .data_o   (product_o),
    .count_o  (fifo_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_r <= '0;
    end else if (issue_ok && !wr) begin
      inflight_r <= inflight_r + cnt_w_lp'(1);
    end else if (wr && !issue_ok) begin
      inflight_r <= inflight_r - cnt_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(issue_v_i && !issue_ready_o))
        else $warning("tail: issue without credit ignored");
      assert (!(v_i && inflight_r == '0))
        else $warning("tail: v_i with nothing in flight ignored");
      assert (!(yumi_i && !v_o))
        else $warning("tail: yumi_i while empty ignored");
    end
  end

endmodule

// File: tb/tb_bsg_mul_array_tail.sv
// Self-checking bench for bsg_mul_array_tail (width_p=16, els_p=4).
// Table vectors, random streaming against a queue model, reset, abuse.
module tb_bsg_mul_array_tail;

  logic clk, rst;
  logic issue_v, issue_ready, v_in, c_in, v_out, yumi;
  logic [15:0] s_in, pa_in;
  logic [31:0] product;

  int total = 0;
  int bad = 0;

  longint mq[$];
  int minfl = 0;

  bsg_mul_array_tail #(.width_p(16), .els_p(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .issue_v_i     (issue_v),
    .issue_ready_o (issue_ready),
    .v_i           (v_in),
    .s_i           (s_in),
    .c_i           (c_in),
    .prod_accum_i  (pa_in),
    .v_o           (v_out),
    .product_o     (product),
    .yumi_i        (yumi)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got,
                     input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  function automatic longint ref_prod(input logic [15:0] s,
                                      input logic c,
                                      input logic [15:0] pa);
    return (longint'(c) * 64'h8000_0000) +
           (longint'(s) / 2) * 65536 + longint'(pa);
  endfunction

  function automatic bit m_ready();
    return (mq.size() + minfl) < 4;
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".v"}, longint'(v_out), longint'(mq.size() > 0));
    chk({tag, ".rdy"}, longint'(issue_ready), longint'(m_ready()));
    if (mq.size() > 0) chk({tag, ".prod"}, longint'(product), mq[0]);
  endtask

  // Apply one cycle of inputs, advance the clock and the model.
  task automatic cyc(input logic iv, input logic v, input logic [15:0] s,
                     input logic c, input logic [15:0] pa,
                     input logic y);
    bit acc_i, acc_v, acc_y;
    issue_v = iv; v_in = v; s_in = s; c_in = c; pa_in = pa; yumi = y;
    acc_i = iv && m_ready();
    acc_v = v && minfl > 0;
    acc_y = y && mq.size() > 0;
    @(posedge clk); #1;
    if (acc_y) void'(mq.pop_front());
    if (acc_v) mq.push_back(ref_prod(s, c, pa));
    minfl += int'(acc_i) - int'(acc_v);
    issue_v = 0; v_in = 0; yumi = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    #7;
    chk("rst.v", longint'(v_out), 0);
    chk("rst.rdy", longint'(issue_ready), 1);
    @(negedge clk);
    rst = 0;
    mq.delete();
    minfl = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic iv, v, y, c;
    logic [15:0] s, pa;
    logic ev, er;
    logic [31:0] ep;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic iv, input logic v,
                              input logic [15:0] s, input logic c,
                              input logic [15:0] pa, input logic y,
                              input logic ev, input logic [31:0] ep,
                              input logic er);
    vec_t r;
    r.iv = iv; r.v = v; r.s = s; r.c = c; r.pa = pa; r.y = y;
    r.ev = ev; r.ep = ep; r.er = er;
    return r;
  endfunction

  initial begin
    issue_v = 0; v_in = 0; s_in = 0; c_in = 0; pa_in = 0; yumi = 0;
    rst = 0;
    #2;
    do_reset();
    chk_model("post_rst");

    // assembly, credit exhaustion, simultaneous events, wrap
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(0, 1, 16'h8003, 1, 16'h1234, 0, 1, 32'hC001_1234, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 2, 0, 1, 0, 1, 32'h0001_0001, 0);
    tbl[8]  = mk(0, 1, 4, 0, 2, 0, 1, 32'h0001_0001, 0);
    tbl[9]  = mk(0, 1, 6, 0, 3, 0, 1, 32'h0001_0001, 0);
    tbl[10] = mk(0, 1, 8, 0, 4, 0, 1, 32'h0001_0001, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 1, 32'h0002_0002, 1);
    tbl[12] = mk(1, 0, 0, 0, 0, 1, 1, 32'h0003_0003, 1);
    tbl[13] = mk(1, 1, 10, 0, 5, 0, 1, 32'h0003_0003, 0);
    tbl[14] = mk(0, 1, 12, 0, 6, 1, 1, 32'h0004_0004, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 1, 32'h0005_0005, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 1, 32'h0006_0006, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1);

    for (int i = 0; i < 18; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      cyc(tbl[i].iv, tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].pa, tbl[i].y);
      chk({nm, ".v"}, longint'(v_out), longint'(tbl[i].ev));
      chk({nm, ".rdy"}, longint'(issue_ready), longint'(tbl[i].er));
      if (tbl[i].ev) chk({nm, ".prod"}, longint'(product),
                         longint'(tbl[i].ep));
      chk_model(nm);
    end

    // random streaming of results 1..10 with stalls
    begin
      int issued, delivered, popped, budget;
      issued = 0; delivered = 0; popped = 0; budget = 0;
      while (popped < 10 && budget < 2000) begin
        bit iv, v, y;
        iv = issued < 10 && m_ready() && ($urandom % 2 == 0);
        v = minfl > 0 && ($urandom % 2 == 0);
        y = mq.size() > 0 && ($urandom % 3 != 0);
        if (y) begin
          popped++;
          chk("stream.order", longint'(product), longint'(popped));
        end
        cyc(iv, v, 0, 0, 16'(delivered + 1), y);
        if (iv) issued++;
        if (v) delivered++;
        chk_model("stream");
        budget++;
      end
      chk("stream.done", longint'(popped), 10);
    end

    // reset mid-operation: 2 buffered, 2 in flight
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 16'h00AA, 0);
    cyc(0, 1, 0, 0, 16'h00BB, 0);
    chk_model("pre_rst");
    chk("pre_rst.rdy0", longint'(issue_ready), 0);
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("post_rst.nov", longint'(v_out), 0);
      chk_model("post_rst2");
    end

    // protocol abuse: spurious v_i, issue without credit, extra yumi
    cyc(0, 1, 2, 0, 16'h5555, 0);
    chk("abuse.v_noinfl", longint'(v_out), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("abuse.yumi_empty", longint'(v_out), 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk_model("abuse.issue");
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 16'(i + 7), 0);
    chk("abuse.full_rdy", longint'(issue_ready), 0);
    cyc(0, 1, 0, 0, 16'h0099, 0);
    chk_model("abuse.v_full");
    for (int i = 0; i < 4; i++) begin
      chk("abuse.drain", longint'(product), longint'(i + 7));
      cyc(0, 0, 0, 0, 0, 1);
      if (i == 0) chk("abuse.credit", longint'(issue_ready), 1);
    end
    chk("abuse.empty", longint'(v_out), 0);
    chk_model("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
